cpu_core: RTL and testbench

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_core.sv | 196 +++++++++++++++++++
 tb/tb_cpu_core.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// cpu_core: single-cycle 8-bit CPU with four registers, a 64x16 code memory
// and a 16x8 data memory. Every instruction is decoded and executed
// combinationally and commits on the next rising clock edge.
module cpu_core (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  switches,
  output logic [15:0]  instr_o,
  output logic [5:0]   pc_o,
  output logic         im_write_o,
  output logic [127:0] data,
  output logic [31:0]  reges,
  output logic [3:0]   flags_out,
  output logic [7:0]   alu_res_o
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3,
    OP_OR   = 4'h4, OP_ADDI = 4'h5, OP_MOVI = 4'h6, OP_MOV  = 4'h7,
    OP_LD   = 4'h8, OP_ST   = 4'h9, OP_STSW = 4'hA, OP_IMW  = 4'hB,
    OP_JMP  = 4'hC, OP_BR   = 4'hD, OP_CMP  = 4'hE, OP_HALT = 4'hF
  } opcode_e;

  // Architectural state. The code memory is deliberately outside reset.
  logic [15:0] imem_q [64];
  logic [7:0]  dmem_q [16];
  logic [7:0]  regs_q [4];
  logic [7:0]  regs_d [4];
  logic [5:0]  pc_q, pc_d;
  logic [3:0]  flags_q, flags_d;   // {C,V,N,Z}

  // Decode and datapath signals
  logic [15:0] instr_s;
  opcode_e     op_s;
  logic [1:0]  rd_s, rs_s;
  logic [7:0]  imm_s, rd_val_s, rs_val_s, add_b_s, and_s, or_s;
  logic [8:0]  sum_s, diff_s;
  logic        add_v_s, sub_v_s, br_take_s;
  logic [7:0]  res_s, rd_wdata_s, dmem_wdata_s;
  logic        reg_we_s, dmem_we_s, imem_we_s;
  logic [3:0]  dmem_addr_s;

  assign instr_s  = imem_q[pc_q];
  assign op_s     = opcode_e'(instr_s[15:12]);
  assign rd_s     = instr_s[11:10];
  assign rs_s     = instr_s[9:8];
  assign imm_s    = instr_s[7:0];
  assign rd_val_s = regs_q[rd_s];
  assign rs_val_s = regs_q[rs_s];
  assign and_s    = rd_val_s & rs_val_s;
  assign or_s     = rd_val_s | rs_val_s;

  // Adder/subtractor with carry and signed-overflow detection
  always_comb begin
    if (op_s == OP_ADDI) begin
      add_b_s = imm_s;
    end else begin
      add_b_s = rs_val_s;
    end
    sum_s   = {1'b0, rd_val_s} + {1'b0, add_b_s};
    diff_s  = {1'b0, rd_val_s} + {1'b0, ~rs_val_s} + 9'd1;
    add_v_s = (rd_val_s[7] == add_b_s[7]) && (sum_s[7] != rd_val_s[7]);
    sub_v_s = (rd_val_s[7] != rs_val_s[7]) && (diff_s[7] != rd_val_s[7]);
  end

  // Branch condition chosen by the rd field, using pre-edge flags
  always_comb begin
    case (rd_s)
      2'b00:   br_take_s = flags_q[0];
      2'b01:   br_take_s = ~flags_q[0];
      2'b10:   br_take_s = flags_q[3];
      2'b11:   br_take_s = flags_q[1];
      default: br_take_s = 1'b0;
    endcase
  end

  // Instruction execute: result mux, flag update, memory writes, next PC
  always_comb begin
    res_s        = 8'd0;
    rd_wdata_s   = 8'd0;
    reg_we_s     = 1'b0;
    flags_d      = flags_q;
    dmem_we_s    = 1'b0;
    dmem_addr_s  = 4'd0;
    dmem_wdata_s = 8'd0;
    imem_we_s    = 1'b0;
    pc_d         = pc_q + 6'd1;
    case (op_s)
      OP_ADD, OP_ADDI: begin
        res_s = sum_s[7:0]; rd_wdata_s = sum_s[7:0]; reg_we_s = 1'b1;
        flags_d = {sum_s[8], add_v_s, sum_s[7], (sum_s[7:0] == 8'd0)};
      end
      OP_SUB: begin
        res_s = diff_s[7:0]; rd_wdata_s = diff_s[7:0]; reg_we_s = 1'b1;
        flags_d = {diff_s[8], sub_v_s, diff_s[7], (diff_s[7:0] == 8'd0)};
      end
      OP_CMP: begin
        res_s = diff_s[7:0];
        flags_d = {diff_s[8], sub_v_s, diff_s[7], (diff_s[7:0] == 8'd0)};
      end
      OP_AND: begin
        res_s = and_s; rd_wdata_s = and_s; reg_we_s = 1'b1;
        flags_d = {1'b0, 1'b0, and_s[7], (and_s == 8'd0)};
      end
      OP_OR: begin
        res_s = or_s; rd_wdata_s = or_s; reg_we_s = 1'b1;
        flags_d = {1'b0, 1'b0, or_s[7], (or_s == 8'd0)};
      end
      OP_MOVI: begin
        res_s = imm_s; rd_wdata_s = imm_s; reg_we_s = 1'b1;
      end
      OP_MOV: begin
        res_s = rs_val_s; rd_wdata_s = rs_val_s; reg_we_s = 1'b1;
      end
      OP_LD: begin
        res_s = rs_val_s; rd_wdata_s = dmem_q[rs_val_s[3:0]]; reg_we_s = 1'b1;
      end
      OP_ST: begin
        res_s = rs_val_s; dmem_we_s = 1'b1;
        dmem_addr_s = rd_val_s[3:0]; dmem_wdata_s = rs_val_s;
      end
      OP_STSW: begin
        res_s = imm_s; dmem_we_s = 1'b1;
        dmem_addr_s = imm_s[3:0]; dmem_wdata_s = switches[7:0];
      end
      OP_IMW: begin
        res_s = rd_val_s; imem_we_s = 1'b1;
      end
      OP_JMP: begin
        pc_d = imm_s[5:0];
      end
      OP_BR: begin
        if (br_take_s) begin
          pc_d = imm_s[5:0];
        end else begin
          pc_d = pc_q + 6'd1;
        end
      end
      OP_HALT: begin
        pc_d = pc_q;
      end
      default: begin
        res_s = 8'd0;
      end
    endcase
  end

  // Next register-file contents: only the addressed register may change
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (reg_we_s && (rd_s == 2'(i))) begin
        regs_d[i] = rd_wdata_s;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Commit PC, registers, flags and data memory; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= 6'd0;
      flags_q <= 4'd0;
      for (int i = 0; i < 4; i++) regs_q[i] <= 8'd0;
      for (int i = 0; i < 16; i++) dmem_q[i] <= 8'd0;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
      if (dmem_we_s) begin
        dmem_q[dmem_addr_s] <= dmem_wdata_s;
      end
    end
  end

  // Code-memory write; suppressed while reset is asserted, contents never cleared
  always_ff @(posedge clk) begin
    if (rst && imem_we_s) begin
      imem_q[rd_val_s[5:0]] <= switches;
    end
  end

  // Flatten memories and registers onto the observation ports
  always_comb begin
    data = 128'd0;
    for (int i = 0; i < 16; i++) data[8*i +: 8] = dmem_q[i];
  end

  assign reges      = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
  assign instr_o    = instr_s;
  assign pc_o       = pc_q;
  assign im_write_o = imem_we_s;
  assign flags_out  = flags_q;
  assign alu_res_o  = res_s;

endmodule

// File: tb/tb_cpu_core.sv
// Directed testbench for cpu_core: preloads code memory, runs short
// programs and compares architectural state against hand-computed values.
module tb_cpu_core;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [15:0]  switches = 16'd0;
  logic [15:0]  instr_o;
  logic [5:0]   pc_o;
  logic         im_write_o;
  logic [127:0] data;
  logic [31:0]  reges;
  logic [3:0]   flags_out;
  logic [7:0]   alu_res_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] prog [64];
  logic [7:0]  sort_in [8];

  cpu_core dut (
    .clk(clk), .rst(rst), .switches(switches), .instr_o(instr_o),
    .pc_o(pc_o), .im_write_o(im_write_o), .data(data), .reges(reges),
    .flags_out(flags_out), .alu_res_o(alu_res_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 16'h0000;
  endtask

  // Hold reset, copy the program into code memory, release reset
  task automatic boot();
    rst = 1'b0;
    step(1);
    for (int i = 0; i < 64; i++) dut.imem_q[i] = prog[i];
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    // ---- MOVI/ADDI overflow ----
    clear_prog();
    prog[0] = 16'h607F;   // MOVI r0,0x7F
    prog[1] = 16'h5001;   // ADDI r0,0x01
    prog[2] = 16'hF000;   // HALT
    boot();
    check_eq("rst_pc",    pc_o,      6'd0);
    check_eq("rst_regs",  reges,     32'd0);
    check_eq("rst_flags", flags_out, 4'd0);
    check_eq("rst_data",  data,      128'd0);
    check_eq("first_instr", instr_o, 16'h607F);
    check_eq("movi_alu",  alu_res_o, 8'h7F);
    step(1);
    check_eq("movi_r0",   reges,     32'h0000007F);
    step(1);
    check_eq("addi_r0",   reges,     32'h00000080);
    check_eq("addi_flags", flags_out, 4'b0110);
    step(3);
    check_eq("halt_pc",   pc_o,      6'd2);

    // ---- CMP / BR Z taken / ADDI carry to zero ----
    clear_prog();
    prog[0]    = 16'h6405;  // MOVI r1,5
    prog[1]    = 16'h6805;  // MOVI r2,5
    prog[2]    = 16'hE600;  // CMP r1,r2
    prog[3]    = 16'hD020;  // BR Z,0x20
    prog[6'h20] = 16'h6C01; // MOVI r3,1
    prog[6'h21] = 16'h5CFF; // ADDI r3,0xFF
    prog[6'h22] = 16'hF000; // HALT
    boot();
    step(3);
    check_eq("cmp_flags", flags_out, 4'b1001);
    check_eq("cmp_pc",    pc_o,      6'd3);
    step(1);
    check_eq("brz_pc",    pc_o,      6'h20);
    check_eq("cmp_regs",  reges,     32'h00050500);
    step(1);
    check_eq("movi_r3",   reges,     32'h01050500);
    step(1);
    check_eq("addi_wrap_regs", reges, 32'h00050500);
    check_eq("addi_wrap_flags", flags_out, 4'b1001);

    // ---- IMW self-modification and PC wrap ----
    clear_prog();
    prog[0]     = 16'h6010; // MOVI r0,0x10
    prog[1]     = 16'hB000; // IMW r0
    prog[2]     = 16'hC010; // JMP 0x10
    prog[6'h11] = 16'hC03F; // JMP 0x3F
    boot();
    switches = 16'h6105;
    check_eq("imw_idle",  im_write_o, 1'b0);
    step(1);
    check_eq("imw_flag",  im_write_o, 1'b1);
    check_eq("imw_alu",   alu_res_o,  8'h10);
    step(2);
    check_eq("jmp_pc",    pc_o,      6'h10);
    check_eq("imw_instr", instr_o,   16'h6105);
    step(1);
    check_eq("imw_exec_r0", reges,   32'h00000005);
    step(1);
    check_eq("jmp_3f",    pc_o,      6'h3F);
    step(1);
    check_eq("pc_wrap",   pc_o,      6'd0);
    switches = 16'd0;

    // ---- STSW fill and bubble sort ----
    clear_prog();
    for (int i = 0; i < 8; i++) prog[i] = 16'hA000 | 16'(i); // STSW i
    prog[8]  = 16'hA00F;  // STSW 15 (pass counter)
    prog[9]  = 16'h6000;  // MOVI r0,0
    prog[10] = 16'h8400;  // LD r1,[r0]
    prog[11] = 16'h7C00;  // MOV r3,r0
    prog[12] = 16'h5C01;  // ADDI r3,1
    prog[13] = 16'h8B00;  // LD r2,[r3]
    prog[14] = 16'hE900;  // CMP r2,r1
    prog[15] = 16'hD812;  // BR C,18
    prog[16] = 16'h9200;  // ST [r0],r2
    prog[17] = 16'h9D00;  // ST [r3],r1
    prog[18] = 16'h7300;  // MOV r0,r3
    prog[19] = 16'h6407;  // MOVI r1,7
    prog[20] = 16'hE100;  // CMP r0,r1
    prog[21] = 16'hD40A;  // BR !Z,10
    prog[22] = 16'h6C0F;  // MOVI r3,15
    prog[23] = 16'h8B00;  // LD r2,[r3]
    prog[24] = 16'h58FF;  // ADDI r2,0xFF
    prog[25] = 16'h9E00;  // ST [r3],r2
    prog[26] = 16'hD409;  // BR !Z,9
    prog[27] = 16'hF000;  // HALT
    sort_in[0] = 8'd7; sort_in[1] = 8'd3; sort_in[2] = 8'd2; sort_in[3] = 8'd1;
    sort_in[4] = 8'd6; sort_in[5] = 8'd4; sort_in[6] = 8'd5; sort_in[7] = 8'd8;
    boot();
    for (int i = 0; i < 8; i++) begin
      switches = {8'd0, sort_in[i]};
      step(1);
    end
    check_eq("stsw_data", data, {64'd0, 64'h0805040601020307});
    switches = 16'h0007;
    step(1);
    switches = 16'h0000;
    for (int c = 0; c < 3000 && instr_o !== 16'hF000; c++) step(1);
    check_eq("sort_halt_reached", instr_o, 16'hF000);
    check_eq("sort_halt_pc", pc_o, 6'd27);
    check_eq("sort_data", data, {64'd0, 64'h0807060504030201});
    step(5);
    check_eq("sort_pc_hold", pc_o, 6'd27);

    // ---- reset after activity ----
    rst = 1'b0;
    step(2);
    check_eq("rst2_pc",    pc_o,      6'd0);
    check_eq("rst2_regs",  reges,     32'd0);
    check_eq("rst2_flags", flags_out, 4'd0);
    check_eq("rst2_data",  data,      128'd0);
    check_eq("rst2_imem",  instr_o,   16'hA000);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
